// File: rtl/pulse_req_tx_if.sv
// pulse_req_tx_if: pulse input, async acknowledge and request/status outputs of pulse_req_tx
interface pulse_req_tx_if #(
    parameter int DROP_W = 8
);
    logic              in;
    logic              ack;
    logic              req;
    logic              busy;
    logic              done;
    logic [DROP_W-1:0] drop_cnt;
    modport master (output in, ack, input req, busy, done, drop_cnt);
    modport slave  (input in, ack, output req, busy, done, drop_cnt);
endinterface

// File: rtl/pulse_req_tx.sv
// pulse_req_tx: turns source-domain pulses into a four-phase req/ack handshake; PULSE_TX_PEND_EN adds a 1-deep pend slot
module pulse_req_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int DROP_W      = 8
) (
    input logic           clk,
    input logic           reset_n,
    pulse_req_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_s, busy, pend, pend_full, launch, in_busy, drop, req_q, done_q;
    logic [DROP_W-1:0]      drop_cnt;
    assign ack_s   = sync[SYNC_STAGES-1];
    assign busy    = (state != IDLE) || ack_s;
    assign launch  = (state == IDLE) && !ack_s && (bus.in || pend);
    assign in_busy = bus.in && (busy || pend);
    assign drop    = in_busy && pend_full;
    assign bus.req      = req_q;
    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.drop_cnt = drop_cnt;
`ifdef PULSE_TX_PEND_EN
    assign pend_full = pend;
    // Hold one pulse that arrived while busy; launching it frees the slot and drops any coincident pulse
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pend <= 1'b0;
        else          pend <= launch ? 1'b0 : (pend || in_busy);
`else
    assign pend      = 1'b0;
    assign pend_full = 1'b1;
`endif
    // Bring the receiver's acknowledge into the clk domain
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sync <= '0;
        else          sync <= {sync[SYNC_STAGES-2:0], bus.ack};
    // Handshake state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    // Four-phase sequencing: launch, wait for ack high, wait for ack low
    always_comb begin
        state_nxt = (state == IDLE) ? (launch ? REQ : IDLE) :
                    (state == REQ)  ? (ack_s ? REL : REQ)   :
                                      (ack_s ? REL : IDLE);
    end
    // Glitch-free registered request, completion pulse and saturating drop counter
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            req_q    <= (state_nxt == REQ);
            done_q   <= (state == REL) && !ack_s;
            drop_cnt <= (drop && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
        end
endmodule

// File: tb/tb_pulse_req_tx.sv
// tb_pulse_req_tx: scoreboard bench for pulse_req_tx against a handshake-occupancy model
module tb_pulse_req_tx;
`ifdef PULSE_TX_PEND_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif
    localparam int HS = 6;
    logic clk = 1'b0;
    logic reset_n;
    logic lb, ack_force;
    always #5 clk = ~clk;
    pulse_req_tx_if #(.DROP_W(8)) a();
    pulse_req_tx_if #(.DROP_W(2)) b();
    assign a.ack = lb ? a.req : ack_force;
    pulse_req_tx #(.SYNC_STAGES(2), .DROP_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(a.slave));
    pulse_req_tx #(.SYNC_STAGES(2), .DROP_W(2)) dut_sat (.clk(clk), .reset_n(reset_n), .bus(b.slave));
    int checks = 0, errors = 0;
    int t, free_at, drop_m, mon_e;
    bit pend_m, chk_on, mon_r;
    int exp_q[$];
    int lq[$];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (edge %0d)", name, act, exp, t);
        end
    endtask
    task automatic mreset();
        t = 0;
        free_at = 0;
        drop_m = 0;
        pend_m = 1'b0;
        exp_q.delete();
        lq.delete();
    endtask
    task automatic launch_m(input int k);
        exp_q.push_back(k + HS);
        lq.push_back(k);
        free_at = k + HS + 1;
    endtask
    task automatic model_edge(input bit v, input int k);
        if (pend_m && k >= free_at) begin
            launch_m(k);
            pend_m = 1'b0;
            if (v) drop_m++;
        end else if (v) begin
            if (k >= free_at) launch_m(k);
            else if (PEND && !pend_m) pend_m = 1'b1;
            else drop_m++;
        end
    endtask
    task automatic step(input bit v);
        a.in = v;
        @(posedge clk);
        model_edge(v, t);
        t++;
        @(negedge clk);
    endtask
    always @(negedge clk) begin
        if (reset_n === 1'b1 && a.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected actual edge %0d expected no done", t - 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_edge", t - 1, mon_e);
            end
        end
        if (chk_on && t > 0) begin
            mon_r = 1'b0;
            foreach (lq[i]) if (lq[i] <= t - 1 && t - 1 <= lq[i] + 2) mon_r = 1'b1;
            check("req_level", a.req, mon_r);
        end
    end
    initial begin
        reset_n = 1'b0;
        lb = 1'b1;
        ack_force = 1'b0;
        a.in = 1'b0;
        b.in = 1'b0;
        b.ack = 1'b0;
        chk_on = 1'b0;
        mreset();
        repeat (2) @(negedge clk);
        check("reset_req", a.req, 0);
        check("reset_busy", a.busy, 0);
        check("reset_done", a.done, 0);
        check("reset_drop", a.drop_cnt, 0);
        reset_n = 1'b1;
        mreset();
        chk_on = 1'b1;
        step(1'b1);
        repeat (9) step(1'b0);
        check("single_drop", a.drop_cnt, 0);
        step(1'b1);
        repeat (6) step(1'b0);
        step(1'b1);
        repeat (9) step(1'b0);
        check("spaced_drop", a.drop_cnt, 0);
        repeat (3) step(1'b1);
        repeat (20) step(1'b0);
        check("held_drop", a.drop_cnt, drop_m);
        check("held_drop_abs", a.drop_cnt, PEND ? 1 : 2);
        repeat (300) step($urandom_range(0, 3) == 0);
        repeat (20) step(1'b0);
        check("random_drop", a.drop_cnt, drop_m);
        check("sb_drained", exp_q.size(), 0);
        chk_on = 1'b0;
        reset_n = 1'b0;
        lb = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step(1'b0);
        check("ackhi_busy", a.busy, 1);
        step(1'b1);
        check("ackhi_req", a.req, 0);
        check("ackhi_busy2", a.busy, 1);
        check("ackhi_drop", a.drop_cnt, PEND ? 0 : 1);
        ack_force = 1'b0;
        repeat (2) step(1'b0);
        check("ackrel_wait", a.req, 0);
        step(1'b0);
        check("ackrel_launch", a.req, PEND);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) step(1'b1);
        check("stuck_req", a.req, 1);
        check("stuck_drop", a.drop_cnt, PEND ? 2 : 3);
        #1 reset_n = 1'b0;
        #1;
        check("async_req", a.req, 0);
        check("async_busy", a.busy, 0);
        check("async_drop", a.drop_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        lb = 1'b1;
        mreset();
        chk_on = 1'b1;
        step(1'b1);
        repeat (9) step(1'b0);
        check("post_reset_drained", exp_q.size(), 0);
        chk_on = 1'b0;
        b.in = 1'b1;
        repeat (6) step(1'b0);
        b.in = 1'b0;
        step(1'b0);
        check("sat_drop", b.drop_cnt, ((PEND ? 4 : 5) > 3) ? 3 : (PEND ? 4 : 5));
        b.in = 1'b1;
        repeat (4) step(1'b0);
        b.in = 1'b0;
        step(1'b0);
        check("sat_hold", b.drop_cnt, 3);
        check("sat_req", b.req, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
